// File: rtl/sub32_serial_if.sv
// Operand/result bundle for the serial subtractor.
// The master drives the operation request; the slave returns registered results.
interface sub32_serial_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic [31:0] d;
  logic        bo;
  logic        zf;
  logic        of;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b, bi,
    input  d, bo, zf, of, busy, done
  );

  modport slave (
    input  start, a, b, bi,
    output d, bo, zf, of, busy, done
  );
endinterface

// File: rtl/sub32_serial.sv
// 32-bit subtractor that walks SLICE bits per cycle, least-significant slice first.
// Results and flags are committed together, so partial differences never reach d.
module sub32_serial #(
  parameter int SLICE = 4
) (
  input  logic           clk,
  input  logic           rst,
  sub32_serial_if.slave  bus
);

  localparam int NSLICE = 32 / SLICE;
  localparam int CW     = $clog2(NSLICE);

  if (!(SLICE == 1 || SLICE == 2 || SLICE == 4 || SLICE == 8)) begin : g_bad_slice
    $error("sub32_serial: SLICE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic            borrow;
  logic [31:0]     res;

  logic [31:0]     d_q;
  logic            bo_q;
  logic            zf_q;
  logic            of_q;
  logic            done_q;

  logic [5:0]      base;
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]  slice_diff;
  logic [31:0]     res_next;
  logic            last;
  logic            of_next;

  assign last = (cnt == CW'(NSLICE - 1));

  // One slice of the borrow chain; the top bit of slice_diff is the outgoing borrow.
  always_comb begin
    base       = 6'(int'(cnt) * SLICE);
    a_slice    = a_q[base +: SLICE];
    b_slice    = b_q[base +: SLICE];
    slice_diff = {1'b0, a_slice} - {1'b0, b_slice} - {{SLICE{1'b0}}, borrow};
    res_next   = res;
    res_next[base +: SLICE] = slice_diff[SLICE-1:0];
    of_next    = (a_q[31] != b_q[31]) && (res_next[31] != a_q[31]);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // done is registered off the DONE state, so it trails the result commit by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      borrow <= 1'b0;
      res    <= '0;
      d_q    <= '0;
      bo_q   <= 1'b0;
      zf_q   <= 1'b0;
      of_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            borrow <= bus.bi;
            cnt    <= '0;
            res    <= '0;
          end
        end
        RUN: begin
          res    <= res_next;
          borrow <= slice_diff[SLICE];
          cnt    <= cnt + 1'b1;
          if (last) begin
            d_q  <= res_next;
            bo_q <= slice_diff[SLICE];
            zf_q <= (res_next == 32'd0);
            of_q <= of_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.d    = d_q;
  assign bus.bo   = bo_q;
  assign bus.zf   = zf_q;
  assign bus.of   = of_q;
  assign bus.done = done_q;
  assign bus.busy = (state != IDLE);

endmodule
